// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor controller.
package serial_sub_pkg;

  // Operand width used when the instantiating design does not override it.
  localparam int DEFAULT_WIDTH = 8;

  // Controller states: waiting for a request, shifting bits, presenting the result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

endpackage

// File: rtl/serial_sub_ctrl_fs_cell.sv
// One-bit full subtractor: two cascaded half-subtractors whose borrows are ORed.
module fs_cell (
  input  logic ai_i,
  input  logic bi_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  logic halfDiff;
  logic halfBorrow1;
  logic halfBorrow2;

  // First stage subtracts bi from ai, second stage subtracts the incoming borrow.
  assign halfDiff    = ai_i ^ bi_i;
  assign halfBorrow1 = ~ai_i & bi_i;
  assign d_o         = halfDiff ^ bin_i;
  assign halfBorrow2 = ~halfDiff & bin_i;
  assign bout_o      = halfBorrow1 | halfBorrow2;

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor: computes a-b one bit per clock, LSB first,
// reusing a single full-subtractor cell and a borrow flop between bits.
module serial_sub_ctrl
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  // Counter is wide enough to hold WIDTH-1 for every legal WIDTH.
  localparam int            CW       = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t           state_q;
  logic [WIDTH-1:0] opA_q, opA_d;
  logic [WIDTH-1:0] opB_q, opB_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q;
  logic             done_q;

  logic bitDiff;
  logic bitBorrow;

  fs_cell uCell (
    .ai_i   (opA_q[0]),
    .bi_i   (opB_q[0]),
    .bin_i  (borrow_q),
    .d_o    (bitDiff),
    .bout_o (bitBorrow)
  );

  // Datapath next values: load operands on an accepted start, shift one bit per RUN cycle.
  always_comb begin
    opA_d    = opA_q;
    opB_d    = opB_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          opA_d    = a;
          opB_d    = b;
          borrow_d = 1'b0;
          cnt_d    = '0;
        end
      end
      RUN: begin
        diff_d   = {bitDiff, diff_q[WIDTH-1:1]};
        opA_d    = {1'b0, opA_q[WIDTH-1:1]};
        opB_d    = {1'b0, opB_q[WIDTH-1:1]};
        borrow_d = bitBorrow;
        cnt_d    = cnt_q + CNT_ONE;
      end
      default: begin
      end
    endcase
  end

  // Controller state, registered status outputs and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      opA_q    <= '0;
      opB_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      opA_q    <= opA_d;
      opB_q    <= opB_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= FIN;
            done_q  <= 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign diff       = diff_q;
  assign borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Self-checking bench for serial_sub_ctrl at WIDTH=8 and WIDTH=5.
module tb_serial_sub_ctrl;

  logic       clock = 1'b0;
  logic       reset;

  logic       start8;
  logic [7:0] a8, b8, diff8;
  logic       busy8, done8, borrow8;

  logic       start5;
  logic [4:0] a5, b5, diff5;
  logic       busy5, done5, borrow5;

  int checkCount = 0;
  int passCount  = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] expDiff;
    logic       expBorrow;
    int         glitchAt;
  } vec_t;

  vec_t vecs[9];

  always #5 clock = ~clock;

  serial_sub_ctrl #(.WIDTH(8)) dut8 (
    .clk        (clock),
    .rst        (reset),
    .start      (start8),
    .a          (a8),
    .b          (b8),
    .busy       (busy8),
    .done       (done8),
    .diff       (diff8),
    .borrow_out (borrow8)
  );

  serial_sub_ctrl #(.WIDTH(5)) dut5 (
    .clk        (clock),
    .rst        (reset),
    .start      (start5),
    .a          (a5),
    .b          (b5),
    .busy       (busy5),
    .done       (done5),
    .diff       (diff5),
    .borrow_out (borrow5)
  );

  // Count every comparison and report any mismatch on one line.
  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  function automatic logic [31:0] maskOf(input int w);
    return (32'h1 << w) - 32'h1;
  endfunction

  // Reference: unsigned subtraction wrapped to w bits, borrow when a < b.
  function automatic logic [31:0] refDiff(input int w, input logic [31:0] av, input logic [31:0] bv);
    return (av - bv) & maskOf(w);
  endfunction

  function automatic logic [31:0] refBorrow(input int w, input logic [31:0] av, input logic [31:0] bv);
    return ((av & maskOf(w)) < (bv & maskOf(w))) ? 32'd1 : 32'd0;
  endfunction

  task automatic setInputs(input int w, input logic s, input logic [31:0] av, input logic [31:0] bv);
    if (w == 8) begin
      start8 = s; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start5 = s; a5 = av[4:0]; b5 = bv[4:0];
    end
  endtask

  function automatic logic getBusy(input int w);
    return (w == 8) ? busy8 : busy5;
  endfunction

  function automatic logic getDone(input int w);
    return (w == 8) ? done8 : done5;
  endfunction

  function automatic logic [31:0] getDiff(input int w);
    return (w == 8) ? 32'(diff8) : 32'(diff5);
  endfunction

  function automatic logic [31:0] getBorrow(input int w);
    return (w == 8) ? 32'(borrow8) : 32'(borrow5);
  endfunction

  // Raise start with the operands and return right after the accepting edge.
  task automatic applyStimulus(input int w, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clock);
    setInputs(w, 1'b1, av, bv);
    @(posedge clock);
  endtask

  // Called just after the accepting edge: scrambles inputs, waits for done and checks the result.
  task automatic waitResult(input int w, input logic [31:0] expDiff, input logic [31:0] expBorrow,
                            input int glitchAt, input string name);
    int k;
    @(negedge clock);
    setInputs(w, 1'b0, $urandom, $urandom);
    checkOutput({name, " busy in run"}, 32'(getBusy(w)), 32'd1);
    k = 0;
    while (getDone(w) !== 1'b1 && k < 3 * w + 10) begin
      @(negedge clock);
      k++;
      if (k == glitchAt) setInputs(w, 1'b1, $urandom, $urandom);
      else if (k == glitchAt + 1) setInputs(w, 1'b0, $urandom, $urandom);
    end
    checkOutput({name, " latency"}, 32'(k), 32'(w));
    checkOutput({name, " diff"}, getDiff(w), expDiff);
    checkOutput({name, " borrow"}, getBorrow(w), expBorrow);
    checkOutput({name, " busy at done"}, 32'(getBusy(w)), 32'd1);
    @(negedge clock);
    checkOutput({name, " done one cycle"}, 32'(getDone(w)), 32'd0);
    checkOutput({name, " idle busy"}, 32'(getBusy(w)), 32'd0);
    checkOutput({name, " diff hold"}, getDiff(w), expDiff);
    checkOutput({name, " borrow hold"}, getBorrow(w), expBorrow);
  endtask

  task automatic checkAllZero(input string name);
    checkOutput({name, " busy8"}, 32'(busy8), 32'd0);
    checkOutput({name, " done8"}, 32'(done8), 32'd0);
    checkOutput({name, " diff8"}, 32'(diff8), 32'd0);
    checkOutput({name, " borrow8"}, 32'(borrow8), 32'd0);
    checkOutput({name, " busy5"}, 32'(busy5), 32'd0);
    checkOutput({name, " done5"}, 32'(done5), 32'd0);
    checkOutput({name, " diff5"}, 32'(diff5), 32'd0);
    checkOutput({name, " borrow5"}, 32'(borrow5), 32'd0);
  endtask

  // Guard against a hung run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Main sequence: reset, directed table, multi-cycle corner cases, random sweep.
  initial begin
    int doneSeen;
    int lastDone;
    int w;
    logic [31:0] av, bv, m;

    vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, -1};
    vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, -1};
    vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, -1};
    vecs[3] = '{8'h10, 8'h01, 8'h0F, 1'b0, -1};
    vecs[4] = '{8'h80, 8'h7F, 8'h01, 1'b0, -1};
    vecs[5] = '{8'h7F, 8'h80, 8'hFF, 1'b1, -1};
    vecs[6] = '{8'h01, 8'h02, 8'hFF, 1'b1, -1};
    vecs[7] = '{8'hC3, 8'h00, 8'hC3, 1'b0, -1};
    vecs[8] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 3};

    reset = 1'b1;
    setInputs(8, 1'b0, 32'h0, 32'h0);
    setInputs(5, 1'b0, 32'h0, 32'h0);
    #1;
    checkAllZero("reset");
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(8, 32'(vecs[i].a), 32'(vecs[i].b));
      waitResult(8, 32'(vecs[i].expDiff), 32'(vecs[i].expBorrow), vecs[i].glitchAt,
                 $sformatf("vec%0d", i));
    end

    // start held high: a result every WIDTH+2 cycles, mid-run operand changes ignored
    @(negedge clock);
    setInputs(8, 1'b1, 32'h10, 32'h01);
    doneSeen = 0;
    lastDone = -1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clock);
      if (c % 10 == 3) setInputs(8, 1'b1, 32'hAA, 32'h55);
      else if (c % 10 == 7) setInputs(8, 1'b1, 32'h10, 32'h01);
      if (done8 === 1'b1) begin
        doneSeen++;
        checkOutput($sformatf("hold start done cycle %0d", c), 32'(c % 10), 32'd9);
        checkOutput("hold start diff", 32'(diff8), 32'h0F);
        checkOutput("hold start borrow", 32'(borrow8), 32'd0);
        if (lastDone >= 0) checkOutput("hold start interval", 32'(c - lastDone), 32'd10);
        lastDone = c;
      end
    end
    checkOutput("hold start pulse count", 32'(doneSeen), 32'd3);
    setInputs(8, 1'b0, 32'h0, 32'h0);
    repeat (12) @(negedge clock);

    // asynchronous reset in the fourth RUN cycle aborts without a done pulse
    applyStimulus(8, 32'h5A, 32'h3C);
    @(negedge clock);
    setInputs(8, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("async reset");
    @(negedge clock);
    reset = 1'b0;
    doneSeen = 0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clock);
      if (done8 === 1'b1) doneSeen++;
    end
    checkOutput("no done after abort", 32'(doneSeen), 32'd0);
    applyStimulus(8, 32'h5A, 32'h3C);
    waitResult(8, 32'h1E, 32'd0, -1, "after abort");

    // start held across reset release is taken at the first edge afterwards
    @(negedge clock);
    reset = 1'b1;
    setInputs(5, 1'b1, 32'h13, 32'h07);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock);
    waitResult(5, 32'h0C, 32'd0, -1, "start across reset");

    // random sweep, corners first, at both widths
    for (int s = 0; s < 2; s++) begin
      w = (s == 0) ? 8 : 5;
      m = maskOf(w);
      for (int i = 0; i < 1000; i++) begin
        case (i)
          0: begin av = 32'h0; bv = 32'h0; end
          1: begin av = 32'h0; bv = m;     end
          2: begin av = m;     bv = 32'h0; end
          3: begin av = m;     bv = m;     end
          default: begin av = $urandom & m; bv = $urandom & m; end
        endcase
        applyStimulus(w, av, bv);
        waitResult(w, refDiff(w, av, bv), refBorrow(w, av, bv), (i % 7 == 0) ? 2 : -1,
                   $sformatf("rand w%0d #%0d a=%0h b=%0h", w, i, av, bv));
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/serial_sub_ctrl.md
SERIAL_SUB_CTRL -- requirements
Module: serial_sub_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand width in bits (legal range 2..32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit; reset is asynchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin one subtraction.
REQ-005 The block SHALL have port a, input, WIDTH bits, the minuend.
REQ-006 The block SHALL have port b, input, WIDTH bits, the subtrahend.
REQ-007 The block SHALL have port busy, output, 1 bit, high while an operation is in progress.
REQ-008 The block SHALL have port done, output, 1 bit, a one-cycle pulse marking a valid result.
REQ-009 The block SHALL have port diff, output, WIDTH bits, the result a-b modulo 2^WIDTH.
REQ-010 The block SHALL have port borrow_out, output, 1 bit, the final borrow (1 iff a<b unsigned).

Function
REQ-011 The FSM SHALL have three states, IDLE, RUN and FIN, and SHALL leave reset in IDLE.
REQ-012 In IDLE with start=1 at a rising edge, the block SHALL load a and b into shift registers, clear the bit counter and the borrow flop, and enter RUN.
REQ-013 The block SHALL ignore start in RUN and FIN, with no effect on operands, counter or outputs.
REQ-014 Each RUN cycle SHALL process one bit, LSB first, with d=ai^bi^bin and bout=(~ai&bi)|(~(ai^bi)&bin), using the current shift-register LSBs and the borrow flop.
REQ-015 Each RUN edge SHALL shift d into the diff register from the MSB end, shift both operand registers right by one, store bout in the borrow flop, and increment the counter.
REQ-016 After exactly WIDTH RUN edges (counter reaches WIDTH-1 and is processed), the FSM SHALL enter FIN.
REQ-017 busy SHALL be 1 in RUN and FIN and 0 in IDLE.
REQ-018 done SHALL be 1 only in FIN, which lasts exactly one cycle; FIN SHALL always return to IDLE.
REQ-019 Latency SHALL be fixed: with start accepted at edge E0, done SHALL be high in the cycle after edge E0+WIDTH, and the block SHALL accept a new start at edge E0+WIDTH+2.
REQ-020 diff and borrow_out SHALL be valid while done=1 and SHALL hold that value until the next accepted start.
REQ-021 While RUN is active, diff SHALL show partial shift contents; it is meaningful only from FIN onward.
REQ-022 a and b SHALL be sampled only at the accepting edge; later changes SHALL NOT affect the result.
REQ-023 Arithmetic SHALL be unsigned with wrap-around; for example, 0-1 SHALL give all-ones with borrow_out=1.

Reset
REQ-024 rst=1 SHALL immediately force state=IDLE and busy=0, done=0, diff=0, borrow_out=0, with counter, shift registers and borrow flop all cleared, regardless of clk.
REQ-025 Reset asserted during RUN or FIN SHALL abort the operation with no done pulse; after release, the next start SHALL behave as from power-up.
REQ-026 Because start is sampled synchronously, start=1 held across reset deassertion SHALL be accepted at the first rising edge after release.

Structure
REQ-027 Package serial_sub_pkg SHALL hold the state enumeration (IDLE, RUN, FIN) and the default-width constant.
REQ-028 The per-bit logic SHALL be one sub-module, fs_cell, a 1-bit full subtractor built from two half-subtractor stages plus an OR of their borrows, instantiated once.
REQ-029 The counter SHALL be $clog2(WIDTH)+1 bits wide, and no other arithmetic SHALL be used in the datapath.

Verification
REQ-030 WIDTH=8, a=0x5A, b=0x3C, start one cycle -> done after 8 RUN cycles, diff=0x1E, borrow_out=0.
REQ-031 a=0x00, b=0x01 -> diff=0xFF, borrow_out=1; then a=0xFF, b=0xFF -> diff=0x00, borrow_out=0.
REQ-032 start held high continuously with a=0x10, b=0x01 -> results 0x0F with done exactly every 10 cycles; a and b changed mid-RUN -> no effect on the result.
REQ-033 Pulse start at cycle 3 of RUN with different operands -> ignored, and the first result is unchanged.
REQ-034 Assert rst asynchronously (between edges) at RUN cycle 4 -> outputs are 0 immediately and no done pulse; a fresh start then gives the correct result.
REQ-035 A random sweep of 1000 operand pairs at WIDTH=8 and WIDTH=5 -> diff and borrow_out match a reference a-b model on every done.
